// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - state encoding and chunk-count helper for the sliced sequential adder
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int dw, input int cw);
        return (dw + cw - 1) / cw;
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational W-bit ripple slice adder exposing its internal carry chain
module add_slice
    import seq_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic [W:0]   carry
);

    // carry[i] is the carry into bit i; carry[W] is the slice carry-out
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/seq_add.sv
// rtl/seq_add.sv - handshaked multi-cycle adder, one CHUNKWIDTH slice per clock; SEQ_ADD_OVF_EN adds ovf
module seq_add
    import seq_add_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int CHUNKWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 cin,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 cout,
`ifdef SEQ_ADD_OVF_EN
    output logic                 ovf,
`endif
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NCHUNK = nchunk(DATAWIDTH, CHUNKWIDTH);
    localparam int PADW   = NCHUNK * CHUNKWIDTH;
    localparam int TOPW   = DATAWIDTH - (NCHUNK - 1) * CHUNKWIDTH;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_t state_q, state_d;

    logic [PADW-1:0]       a_q;
    logic [PADW-1:0]       b_q;
    logic                  carry_q;
    logic [KW-1:0]         k_q;
    logic                  accept;
    logic                  last;
    logic [CHUNKWIDTH-1:0] a_sl;
    logic [CHUNKWIDTH-1:0] b_sl;
    logic [CHUNKWIDTH-1:0] s_sl;
    logic [CHUNKWIDTH:0]   c_sl;
    logic                  slice_cout;
    logic                  unused_carry;

    assign last   = (k_q == KLAST);
    assign accept = in_valid & in_ready;

    // operands are stored zero-padded so the top slice needs no special masking
    assign a_sl = a_q[k_q * CHUNKWIDTH +: CHUNKWIDTH];
    assign b_sl = b_q[k_q * CHUNKWIDTH +: CHUNKWIDTH];

    add_slice #(
        .W(CHUNKWIDTH)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (s_sl),
        .carry(c_sl)
    );

    // the top slice carries out of its real width, not out of the padding
    assign slice_cout   = last ? c_sl[TOPW] : c_sl[CHUNKWIDTH];
    assign unused_carry = ^c_sl;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (Rst) in_ready = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= PADW'(a);
            b_q     <= PADW'(b);
            carry_q <= cin;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < DATAWIDTH; i++) begin
                if (k_q == KW'(i / CHUNKWIDTH)) sum[i] <= s_sl[i % CHUNKWIDTH];
            end
            carry_q <= slice_cout;
            k_q     <= k_q + 1'b1;
            if (last) begin
                cout <= slice_cout;
`ifdef SEQ_ADD_OVF_EN
                ovf  <= c_sl[TOPW] ^ c_sl[TOPW-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_add.sv
// tb/tb_seq_add.sv - directed checks of seq_add at 32/8, 12/8 and 16/16 configurations
module tb_seq_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_v = '0;
    logic [31:0] b_v = '0;
    logic        cin_v = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  iv = '0;

    logic [31:0] sum0;
    logic [11:0] sum1;
    logic [15:0] sum2;
    logic        cout0, cout1, cout2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
`ifdef SEQ_ADD_OVF_EN
    logic        ovf0, ovf1, ovf2;
`endif

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;

    logic [31:0] sum_s;
    logic        cout_s, ir_s, ov_s;

    always #5 clk = ~clk;

    seq_add #(.DATAWIDTH(32), .CHUNKWIDTH(8)) dut0 (
        .Clk(clk), .Rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_v), .b(b_v), .cin(cin_v), .sum(sum0), .cout(cout0),
`ifdef SEQ_ADD_OVF_EN
        .ovf(ovf0),
`endif
        .out_valid(ov0), .out_ready(out_ready)
    );

    seq_add #(.DATAWIDTH(12), .CHUNKWIDTH(8)) dut1 (
        .Clk(clk), .Rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_v[11:0]), .b(b_v[11:0]), .cin(cin_v), .sum(sum1), .cout(cout1),
`ifdef SEQ_ADD_OVF_EN
        .ovf(ovf1),
`endif
        .out_valid(ov1), .out_ready(out_ready)
    );

    seq_add #(.DATAWIDTH(16), .CHUNKWIDTH(16)) dut2 (
        .Clk(clk), .Rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .a(a_v[15:0]), .b(b_v[15:0]), .cin(cin_v), .sum(sum2), .cout(cout2),
`ifdef SEQ_ADD_OVF_EN
        .ovf(ovf2),
`endif
        .out_valid(ov2), .out_ready(out_ready)
    );

    always_comb begin
        case (sel)
            0: begin sum_s = sum0;             cout_s = cout0; ir_s = ir0; ov_s = ov0; end
            1: begin sum_s = {20'd0, sum1};    cout_s = cout1; ir_s = ir1; ov_s = ov1; end
            default: begin sum_s = {16'd0, sum2}; cout_s = cout2; ir_s = ir2; ov_s = ov2; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge while the selected DUT can accept; leaves it in DONE with out_ready low
    task automatic run_add(input int s, input logic [31:0] a, input logic [31:0] b, input logic c,
                           input int nc, input logic [31:0] es, input logic ec);
        sel   = s;
        a_v   = a;
        b_v   = b;
        cin_v = c;
        iv    = 3'(1 << s);
        #1;
        check("accept_ready", 32'(ir_s), 32'd1);
        @(posedge clk);
        for (int i = 0; i <= nc; i++) begin
            @(negedge clk);
            iv        = '0;
            out_ready = 1'b0;
            check("latency_valid", 32'(ov_s), 32'(i == nc));
        end
        check("sum", sum_s, es);
        check("cout", 32'(cout_s), 32'(ec));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("consume_valid", 32'(ov_s), 32'd0);
        check("consume_ready", 32'(ir_s), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_sum", sum0, 32'd0);
        check("rst_cout", 32'(cout0), 32'd0);
        check("rst_valid", 32'(ov0), 32'd0);
        check("rst_ready", 32'(ir0), 32'd0);
`ifdef SEQ_ADD_OVF_EN
        check("rst_ovf", 32'(ovf0), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ir0), 32'd1);

        run_add(0, 32'h000000FF, 32'h00000001, 1'b0, 4, 32'h00000100, 1'b0);
        consume();

        run_add(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4, 32'h00000000, 1'b1);
        a_v = 32'd99;
        b_v = 32'd99;
        iv  = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_sum", sum0, 32'h00000000);
            check("bp_cout", 32'(cout0), 32'd1);
            check("bp_valid", 32'(ov0), 32'd1);
            check("bp_ready", 32'(ir0), 32'd0);
        end
        out_ready = 1'b1;
        run_add(0, 32'd2, 32'd3, 1'b0, 4, 32'd5, 1'b0);
        consume();

        run_add(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4, 32'h80000000, 1'b0);
`ifdef SEQ_ADD_OVF_EN
        check("ovf", 32'(ovf0), 32'd1);
`endif
        consume();

        sel = 0;
        a_v = 32'd5;
        b_v = 32'd6;
        cin_v = 1'b0;
        iv  = 3'b001;
        @(posedge clk);
        @(negedge clk);
        iv  = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(ov0), 32'd0);
        check("abort_sum", sum0, 32'd0);
        check("abort_ready", 32'(ir0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(ov0), 32'd0);
        end
        run_add(0, 32'd10, 32'd20, 1'b1, 4, 32'd31, 1'b0);
        consume();

        run_add(1, 32'h00000FFF, 32'h00000001, 1'b0, 2, 32'h00000000, 1'b1);
        consume();
        run_add(1, 32'h000000FF, 32'h00000001, 1'b0, 2, 32'h00000100, 1'b0);
        consume();

        run_add(2, 32'h00008000, 32'h00008000, 1'b1, 1, 32'h00000001, 1'b1);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
